// File: rtl/anubis_2_pkg.sv
// -----------------------------------------------------------------------------
// anubis_2_pkg
// Shared constants, types and GF(2^8) helpers for the iterative Anubis-128
// encryptor (tweaked S-box, tweaked key schedule, 128-bit key and block).
//
// Block/key layout: a 128-bit word holds a 4x4 byte matrix, row-major, MSB
// first, so a[i][j] lives at bits [127-8(4i+j) -: 8], i.e. byte index
// 15-(4i+j) of blk_t.
// -----------------------------------------------------------------------------
package anubis_2_pkg;

    localparam int unsigned R = 12;             // rounds
    localparam int unsigned N = 4;              // key words (rows)
    localparam logic [8:0]  POLY = 9'h11D;      // x^8+x^4+x^3+x^2+1
    localparam logic [3:0]  LAST_RND = 4'(R);

    // had(01,02,04,06) first row; H[i][j] = H_COEF[i ^ j]
    localparam logic [3:0][7:0]   H_COEF = {8'h06, 8'h04, 8'h02, 8'h01};
    // vdm(01,02,06,08) generators; V[i][j] = V_COEF[i]^j
    localparam logic [N-1:0][7:0] V_COEF = {8'h08, 8'h06, 8'h02, 8'h01};

    typedef enum logic [1:0] {
        ORD_LOAD_KEY = 2'b00,
        ORD_LOAD_PT  = 2'b01,
        ORD_RUN      = 2'b10,
        ORD_HOLD     = 2'b11
    } order_e;

    typedef logic [15:0][7:0] blk_t;

    // Byte index of matrix element [i][j] inside blk_t.
    function automatic int bidx(int i, int j);
        return 15 - (4 * i + j);
    endfunction

    function automatic logic [7:0] xtime(logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY[7:0] : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Mini-boxes of the tweaked S-box.
    function automatic logic [3:0] mini_p(logic [3:0] x);
        case (x)
            4'h0: mini_p = 4'h3;  4'h1: mini_p = 4'hF;
            4'h2: mini_p = 4'hE;  4'h3: mini_p = 4'h0;
            4'h4: mini_p = 4'h5;  4'h5: mini_p = 4'h4;
            4'h6: mini_p = 4'hB;  4'h7: mini_p = 4'hC;
            4'h8: mini_p = 4'hD;  4'h9: mini_p = 4'hA;
            4'hA: mini_p = 4'h9;  4'hB: mini_p = 4'h6;
            4'hC: mini_p = 4'h7;  4'hD: mini_p = 4'h8;
            4'hE: mini_p = 4'h2;  default: mini_p = 4'h1;
        endcase
    endfunction

    function automatic logic [3:0] mini_q(logic [3:0] x);
        case (x)
            4'h0: mini_q = 4'h9;  4'h1: mini_q = 4'hE;
            4'h2: mini_q = 4'h5;  4'h3: mini_q = 4'h6;
            4'h4: mini_q = 4'hA;  4'h5: mini_q = 4'h2;
            4'h6: mini_q = 4'h3;  4'h7: mini_q = 4'hC;
            4'h8: mini_q = 4'hF;  4'h9: mini_q = 4'h0;
            4'hA: mini_q = 4'h4;  4'hB: mini_q = 4'hD;
            4'hC: mini_q = 4'h7;  4'hD: mini_q = 4'hB;
            4'hE: mini_q = 4'h1;  default: mini_q = 4'h8;
        endcase
    endfunction

    // Three P/Q layers; between layers the low two bits of the upper nibble
    // trade places with the high two bits of the lower nibble.
    function automatic logic [7:0] sbox_f(logic [7:0] x);
        logic [3:0] u1, l1, u2, l2;
        u1 = mini_p(x[7:4]);
        l1 = mini_q(x[3:0]);
        u2 = mini_q({u1[3:2], l1[3:2]});
        l2 = mini_p({u1[1:0], l1[1:0]});
        return {mini_p({u2[3:2], l2[3:2]}), mini_q({u2[1:0], l2[1:0]})};
    endfunction

    // Row 0 of round constant c^r is S[4(r-1)+j]; entry r-1 holds it.
    function automatic logic [R-1:0][31:0] gen_rc();
        logic [R-1:0][31:0] t;
        for (int r = 0; r < int'(R); r++) begin
            for (int j = 0; j < 4; j++) begin
                t[r][31 - 8 * j -: 8] = sbox_f(8'(4 * r + j));
            end
        end
        return t;
    endfunction

    localparam logic [R-1:0][31:0] RC_ROM = gen_rc();

    // theta: b = a * H
    function automatic blk_t theta(blk_t a);
        blk_t       b;
        logic [7:0] acc;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc ^= gmul(a[bidx(i, k)], H_COEF[k ^ j]);
                end
                b[bidx(i, j)] = acc;
            end
        end
        return b;
    endfunction

    // omega: b = V^T * a, so row i of b = XOR_k V_COEF[k]^i * row k of a.
    function automatic blk_t omega(blk_t a);
        blk_t             b;
        logic [N-1:0][7:0] pw;
        logic [7:0]       acc;
        b  = '0;
        pw = {N{8'h01}};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < int'(N); k++) begin
                    acc ^= gmul(pw[k], a[bidx(k, j)]);
                end
                b[bidx(i, j)] = acc;
            end
            for (int k = 0; k < int'(N); k++) pw[k] = gmul(pw[k], V_COEF[k]);
        end
        return b;
    endfunction

    // pi: column j rotated down by j rows.
    function automatic blk_t pi_f(blk_t a);
        blk_t b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                b[bidx(i, j)] = a[bidx((i - j) & 3, j)];
            end
        end
        return b;
    endfunction

    function automatic blk_t tau(blk_t a);
        blk_t b;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                b[bidx(i, j)] = a[bidx(j, i)];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/anubis_2_if.sv
// -----------------------------------------------------------------------------
// anubis_2_if
// Command/data bundle of the Anubis-128 core.
//   order    : command (load key / load plaintext / run / hold)
//   data_in  : key or plaintext, depending on order
//   data_out : registered ciphertext
// master = the controller driving commands, slave = the core.
// -----------------------------------------------------------------------------
interface anubis_2_if;
    import anubis_2_pkg::*;

    order_e       order;
    logic [127:0] data_in;
    logic [127:0] data_out;

    modport master (output order, output data_in, input data_out);
    modport slave  (input order, input data_in, output data_out);
endinterface

// File: rtl/anubis_2_sbox.sv
// -----------------------------------------------------------------------------
// anubis_2_sbox
// Tweaked Anubis S-box, purely combinational, built from the P/Q mini-boxes.
// The construction lives in the package so the round-constant ROM is derived
// from exactly the same function.
//   din  : 8-bit input byte
//   dout : 8-bit substituted byte
// -----------------------------------------------------------------------------
module anubis_2_sbox
    import anubis_2_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);
    assign dout = sbox_f(din);
endmodule

// File: rtl/anubis_2.sv
// -----------------------------------------------------------------------------
// anubis_2
// Iterative Anubis-128 encryptor, one round per clock, round keys generated
// on the fly from the evolving key state.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every register
//   bus   : anubis_2_if.slave (order, data_in, data_out)
// Command order 01 is edge 0; after the 12th order-10 edge data_out carries
// the ciphertext. order 11 stalls, 00/01 restart.
// -----------------------------------------------------------------------------
module anubis_2
    import anubis_2_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    anubis_2_if.slave  bus
);

    blk_t       key_reg;    // loaded key K^0
    blk_t       kstate;     // key state K^(rnd-1) while running
    blk_t       state;      // cipher state
    blk_t       dout;
    logic [3:0] rnd;        // 0 idle, 1..12 next round to run, 13 done

    blk_t        g_k, g_kk, g_st;
    blk_t        k_next, kk_src, kk, st_mix, st_next;
    logic [31:0] rc_word;
    logic        run_ok;

    // Three gamma layers: key evolution, round-key extraction, data path.
    for (genvar b = 0; b < 16; b++) begin : g_gamma
        anubis_2_sbox u_sb_k  (.din(kstate[b]), .dout(g_k[b]));
        anubis_2_sbox u_sb_kk (.din(kk_src[b]), .dout(g_kk[b]));
        anubis_2_sbox u_sb_st (.din(state[b]),  .dout(g_st[b]));
    end

    assign run_ok = (rnd >= 4'd1) && (rnd <= LAST_RND);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rc_word = '0;
        if (run_ok) rc_word = RC_ROM[rnd - 4'd1];
    end

    assign k_next = theta(pi_f(g_k)) ^ {rc_word, 96'h0};

    // On a plaintext load the round-key gamma layer sees the key register to
    // form KK^0; otherwise it sees the freshly evolved K^rnd. Sharing the
    // layer keeps the core at 48 S-boxes.
    assign kk_src  = (bus.order == ORD_LOAD_PT) ? key_reg : k_next;
    assign kk      = omega(g_kk);
    assign st_mix  = tau(g_st);
    assign st_next = ((rnd == LAST_RND) ? st_mix : theta(st_mix)) ^ kk;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data-path registers are cleared too, so no stale key
            // or plaintext survives a reset.
            key_reg <= '0;
            kstate  <= '0;
            state   <= '0;
            dout    <= '0;
            rnd     <= '0;
        end else begin
            case (bus.order)
                ORD_LOAD_KEY: begin
                    key_reg <= bus.data_in;
                    kstate  <= bus.data_in;
                    rnd     <= '0;
                end
                ORD_LOAD_PT: begin
                    state  <= bus.data_in ^ kk;
                    kstate <= key_reg;
                    rnd    <= 4'd1;
                end
                ORD_RUN: begin
                    if (run_ok) begin
                        kstate <= k_next;
                        state  <= st_next;
                        rnd    <= rnd + 4'd1;
                        if (rnd == LAST_RND) dout <= st_next;
                    end
                end
                ORD_HOLD: ;
            endcase
        end
    end

    assign bus.data_out = dout;

endmodule

// File: tb/tb_anubis_2.sv
// -----------------------------------------------------------------------------
// tb_anubis_2
// Self-checking bench for anubis_2 with a matrix-level reference model.
// -----------------------------------------------------------------------------
module tb_anubis_2;
    import anubis_2_pkg::*;

    logic clk;
    logic reset;
    anubis_2_if bus ();

    anubis_2 dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [127:0] exp_out;   // what data_out must show right now

    // ---------------- reference model ----------------
    int mp[16] = '{3, 15, 14, 0, 5, 4, 11, 12, 13, 10, 9, 6, 7, 8, 2, 1};
    int mq[16] = '{9, 14, 5, 6, 10, 2, 3, 12, 15, 0, 4, 13, 7, 11, 1, 8};
    int sb[256];
    logic [127:0] h_mat, vt_mat;

    function automatic int gb(logic [127:0] v, int i, int j);
        return int'(v[127 - 8 * (4 * i + j) -: 8]);
    endfunction

    function automatic logic [127:0] pb(logic [127:0] v, int i, int j, int x);
        logic [7:0] b;
        b = x[7:0];
        v[127 - 8 * (4 * i + j) -: 8] = b;
        return v;
    endfunction

    // carry-less product then long division by 0x11D
    function automatic int gf_mul(int a, int b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) r ^= a << i;
        for (int d = 14; d >= 8; d--) if (((r >> d) & 1) != 0) r ^= 'h11D << (d - 8);
        return r;
    endfunction

    function automatic logic [127:0] m_matmul(logic [127:0] a, logic [127:0] b);
        logic [127:0] c;
        int acc;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc ^= gf_mul(gb(a, i, k), gb(b, k, j));
                c = pb(c, i, j, acc);
            end
        return c;
    endfunction

    function automatic logic [127:0] m_gamma(logic [127:0] a);
        logic [127:0] c;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c = pb(c, i, j, sb[gb(a, i, j)]);
        return c;
    endfunction

    function automatic logic [127:0] m_tau(logic [127:0] a);
        logic [127:0] c;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c = pb(c, i, j, gb(a, j, i));
        return c;
    endfunction

    function automatic logic [127:0] m_pi(logic [127:0] a);
        logic [127:0] c;
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c = pb(c, i, j, gb(a, (i - j + 4) % 4, j));
        return c;
    endfunction

    function automatic logic [127:0] m_const(int r);
        logic [127:0] c;
        c = '0;
        for (int j = 0; j < 4; j++) c = pb(c, 0, j, sb[4 * (r - 1) + j]);
        return c;
    endfunction

    function automatic logic [127:0] ref_encrypt(logic [127:0] key, logic [127:0] pt);
        logic [127:0] k, st;
        k  = key;
        st = pt ^ m_matmul(vt_mat, m_gamma(k));
        for (int r = 1; r <= 12; r++) begin
            k  = m_matmul(m_pi(m_gamma(k)), h_mat) ^ m_const(r);
            st = m_tau(m_gamma(st));
            if (r < 12) st = m_matmul(st, h_mat);
            st = st ^ m_matmul(vt_mat, m_gamma(k));
        end
        return st;
    endfunction

    task automatic build_model();
        int hc[4] = '{1, 2, 4, 6};
        int vc[4] = '{1, 2, 6, 8};
        int u, l, u2, l2, p;
        for (int x = 0; x < 256; x++) begin
            u  = mp[x >> 4];
            l  = mq[x & 15];
            u2 = mq[(u & 12) | (l >> 2)];
            l2 = mp[((u & 3) << 2) | (l & 3)];
            sb[x] = (mp[(u2 & 12) | (l2 >> 2)] << 4) | mq[((u2 & 3) << 2) | (l2 & 3)];
        end
        h_mat  = '0;
        vt_mat = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                h_mat = pb(h_mat, i, j, hc[i ^ j]);
                p = 1;
                for (int e = 0; e < i; e++) p = gf_mul(p, vc[j]);
                vt_mat = pb(vt_mat, i, j, p);   // V^T[i][j] = v_j^i
            end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input order_e o, input logic [127:0] d);
        bus.order   = o;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    // Load key (3 edges), plaintext (1 edge), then 16 run edges, optionally
    // with a 3-edge hold inserted after run edge stall_after.
    task automatic run_encrypt(input logic [127:0] key, input logic [127:0] pt,
                               input int stall_after, input string nm);
        logic [127:0] exp;
        exp = ref_encrypt(key, pt);
        for (int i = 0; i < 3; i++) drive(ORD_LOAD_KEY, key);
        drive(ORD_LOAD_PT, pt);
        n_total++;
        if (bus.data_out !== exp_out)
            $display("FAIL %s load: data_out=%h required=%h", nm, bus.data_out, exp_out);
        else n_pass++;
        for (int e = 1; e <= 16; e++) begin
            if (stall_after != 0 && e == stall_after + 1) begin
                for (int s = 0; s < 3; s++) begin
                    drive(ORD_HOLD, rand128());
                    n_total++;
                    if (bus.data_out !== exp_out)
                        $display("FAIL %s stall%0d: data_out=%h required=%h", nm, s, bus.data_out, exp_out);
                    else n_pass++;
                end
            end
            drive(ORD_RUN, rand128());
            if (e == 12) exp_out = exp;
            n_total++;
            if (bus.data_out !== exp_out)
                $display("FAIL %s run_edge%0d: data_out=%h required=%h", nm, e, bus.data_out, exp_out);
            else n_pass++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) drive(order_e'($urandom_range(0, 3)), rand128());
        exp_out = '0;
        n_total++;
        if (bus.data_out !== 128'h0) $display("FAIL reset_dout: data_out=%h required=0", bus.data_out);
        else n_pass++;
        n_total++;
        if (dut.rnd !== 4'd0) $display("FAIL reset_rnd: rnd=%0d required=0", dut.rnd);
        else n_pass++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ORD_RUN, rand128());
            n_total++;
            if (bus.data_out !== 128'h0)
                $display("FAIL reset_idle_run%0d: data_out=%h required=0", i, bus.data_out);
            else n_pass++;
        end
    endtask

    task automatic test_vectors();
        run_encrypt({8'h80, 120'h0}, 128'h0, 0, "nessie_set1_v0");
        run_encrypt({16{8'h01}}, {16{8'h01}}, 0, "ones_01");
        // back-to-back: previous ciphertext must hold until this run completes
        run_encrypt(128'h0, 128'h0, 0, "zero");
        for (int t = 0; t < 3; t++) run_encrypt(rand128(), rand128(), 0, "random");
    endtask

    task automatic test_stall();
        logic [127:0] key, pt;
        key = rand128();
        pt  = rand128();
        run_encrypt(key, pt, 5, "stall5");
        run_encrypt(rand128(), rand128(), 11, "stall11");
    endtask

    task automatic test_restart();
        logic [127:0] key, key2, pt_b, exp;
        key  = rand128();
        key2 = rand128();
        pt_b = rand128();
        drive(ORD_LOAD_KEY, key);
        drive(ORD_LOAD_PT, rand128());
        for (int e = 0; e < 6; e++) drive(ORD_RUN, rand128());
        // abort with a fresh plaintext under the same key
        drive(ORD_LOAD_PT, pt_b);
        exp = ref_encrypt(key, pt_b);
        for (int e = 1; e <= 12; e++) begin
            drive(ORD_RUN, rand128());
            if (e == 12) exp_out = exp;
            n_total++;
            if (bus.data_out !== exp_out)
                $display("FAIL restart_pt edge%0d: data_out=%h required=%h", e, bus.data_out, exp_out);
            else n_pass++;
        end
        // abort mid-run with a key reload, then a normal run under the new key
        drive(ORD_LOAD_PT, rand128());
        for (int e = 0; e < 4; e++) drive(ORD_RUN, rand128());
        run_encrypt(key2, rand128(), 0, "restart_key");
    endtask

    task automatic test_reset_abort();
        drive(ORD_LOAD_KEY, rand128());
        drive(ORD_LOAD_PT, rand128());
        for (int e = 1; e <= 5; e++) begin
            drive(ORD_RUN, rand128());
            n_total++;
            if (bus.data_out !== exp_out)
                $display("FAIL abort_pre edge%0d: data_out=%h required=%h", e, bus.data_out, exp_out);
            else n_pass++;
        end
        reset = 1'b1;
        drive(ORD_RUN, rand128());
        reset = 1'b0;
        exp_out = '0;
        n_total++;
        if (bus.data_out !== 128'h0) $display("FAIL abort_dout: data_out=%h required=0", bus.data_out);
        else n_pass++;
        n_total++;
        if (dut.rnd !== 4'd0) $display("FAIL abort_rnd: rnd=%0d required=0", dut.rnd);
        else n_pass++;
        for (int e = 0; e < 16; e++) begin
            drive(ORD_RUN, rand128());
            n_total++;
            if (bus.data_out !== 128'h0)
                $display("FAIL abort_post edge%0d: data_out=%h required=0", e, bus.data_out);
            else n_pass++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.order   = ORD_HOLD;
        bus.data_in = '0;
        exp_out     = '0;
        build_model();
        test_reset();
        test_vectors();
        test_stall();
        test_restart();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
